id_issue_queue: RTL and testbench
=================================

Name: id_issue_queue

Overview:
- Dual-issue instruction buffer between the IF stage and the IF/ID pipeline register.
- Accepts 0–2 fetched instructions per cycle from the two IF lines. Presents the oldest 0–2 to the ID register under valid/allowin handshake.
- Decouples fetch bursts from decode stalls. Discards all contents on exception or branch flush.

Parameters:
- DEPTH, 8, number of instruction slots; power of 2, minimum 4.
- INST_W, 64, width of one slot payload ({pc, inst}).
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridable).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_line1_valid_i  in  1  IF line1 offers an instruction.
- in_line2_valid_i  in  1  IF line2 offers an instruction (program order after line1).
- in_line1_data_i  in  INST_W  line1 payload.
- in_line2_data_i  in  INST_W  line2 payload.
- queue_allowin_o  out  1  queue can take two instructions this cycle.
- out_allowin_i  in  1  ID pipeline register accepts this cycle.
- out_line1_valid_o  out  1  oldest entry presented.
- out_line2_valid_o  out  1  second-oldest entry presented.
- out_line1_data_o  out  INST_W  oldest payload; 0 when invalid.
- out_line2_data_o  out  INST_W  second payload; 0 when invalid.
- excep_flush_i  in  1  exception flush.
- branch_flush_i  in  1  branch mispredict flush.
- count_o  out  CNT_W  current occupancy, for debug and perf counters.

Behaviour:
- **State:** circular buffer with rd_ptr, wr_ptr (log2 DEPTH bits, wrap modulo DEPTH) and count (CNT_W bits).
  - Async reset clears rd_ptr, wr_ptr and count to 0. Storage is not reset.
  - After reset, all outputs are 0 and queue_allowin_o=1.
- **allowin:** queue_allowin_o = (count <= DEPTH-2) && !flush, where flush = excep_flush_i | branch_flush_i.
  - Depends only on registered count and flush. There is no combinational path from out_allowin_i.
- **Push:** push_n = queue_allowin_o ? (in_line1_valid_i + in_line2_valid_i) : 0.
  - Compaction: if only line2 is valid, its payload is written at wr_ptr as if it were line1.
  - Two pushes write wr_ptr then wr_ptr+1 (mod DEPTH).
  - wr_ptr advances by push_n.
- **Presentation** (combinational from registered state):
  - out_line1_valid_o = (count>=1) && !flush.
  - out_line2_valid_o = (count>=2) && !flush.
  - Data is read from rd_ptr and rd_ptr+1 (mod DEPTH), zero-masked when the matching valid is 0.
- **Pop:** pop_n = out_allowin_i ? (out_line1_valid_o + out_line2_valid_o) : 0.
  - rd_ptr advances by pop_n. Line2 is never popped without line1.
- **Count:** count_next = count + push_n - pop_n. Simultaneous push and pop are legal in the same cycle.
  - Since allowin requires at least 2 free slots, overflow cannot occur.
  - Since pop_n <= count, underflow cannot occur.
- **Flush:** on posedge with flush=1, rd_ptr, wr_ptr and count go to 0.
  - Inputs are ignored that cycle (allowin forced 0). Outputs are invalid that cycle.
  - The downstream register also clears on the same flush.
  - Flush has priority over push and pop.
- **Latency:** an instruction pushed in cycle N is presentable in cycle N+1 at the earliest. There is no bypass.
- **Ordering:** strict program order. Line1 of a cycle is always older than line2 of the same cycle, and both are older than any later push.
- **Reset mid-operation:** asserting rst_n=0 asynchronously empties the queue regardless of in-flight handshakes.

Decomposition:
- The shared bus-width header holds INST_W-equivalent fetch-bus width macros and the reset-enable constant.
- Queue-local constants (CNT_W, pointer width) are localparams.
- One natural sub-module, iq_regfile: DEPTH x INST_W array with two write ports (consecutive addresses) and two asynchronous read ports. It contains no reset logic.
- Pointer, count and handshake logic stay in id_issue_queue.

Test Plan:
1. **Reset, then single pushes:** push line1 only with A=0x1C000000_02800000, then B.
   - count_o=1, then 2.
   - Cycle after first push: out_line1_valid_o=1 with A.
   - After second push: out_line2_valid_o=1 with B.
2. **Compaction:** push line2 only with C when the queue is empty.
   - Next cycle out_line1_data_o=C, out_line2_valid_o=0, count_o=1.
3. **Fill and wrap, DEPTH=8:** push pairs with out_allowin_i=0 until count_o=6.
   - queue_allowin_o=0 at count=7 and 8. Never exceeds 8.
   - Then pop 2 per cycle while pushing 2 per cycle for 10 cycles: rd_ptr and wr_ptr wrap past 7, and the output order matches the push order exactly.
4. **Simultaneous push/pop:** with count=3, push 2 and pop 2 in the same cycle.
   - count_o=3 next cycle. Head equals the former third entry.
5. **Flush priority:** with count=5, assert branch_flush_i together with both in_lineX_valid_i and out_allowin_i.
   - Same cycle: both out valids 0 and queue_allowin_o=0.
   - Next cycle: count_o=0, nothing presented, and the pushed data is never seen.
6. **Async reset mid-stream:** drop rst_n between clock edges with count=4.
   - Outputs go invalid immediately and count_o=0.
   - After release, the first push reappears correctly at the head.

Source files
------------

// File: rtl/id_issue_queue_pkg.sv
// Shared constants for the instruction-fetch / decode boundary.
//   FETCH_PC_W, FETCH_INST_W : fields of one fetched instruction
//   FETCH_BUS_W              : one fetch-bus slot, {pc, inst}
//   RST_N_ACTIVE             : level at which rst_n resets state
package id_issue_queue_pkg;

  localparam int unsigned FETCH_PC_W   = 32;
  localparam int unsigned FETCH_INST_W = 32;
  localparam int unsigned FETCH_BUS_W  = FETCH_PC_W + FETCH_INST_W;

  localparam logic RST_N_ACTIVE = 1'b0;

  // Number of set bits in a pair of line valids (0..2).
  function automatic logic [1:0] pair_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/iq_regfile.sv
// Instruction slot storage for id_issue_queue.
//   clk        : write clock
//   i_we0/1    : write enables; port1 writes the slot after port0
//   i_waddr    : slot for write port0 (port1 uses i_waddr+1 mod DEPTH)
//   i_wdata0/1 : write payloads
//   i_raddr    : slot for read port0 (port1 reads i_raddr+1 mod DEPTH)
//   o_rdata0/1 : asynchronous read payloads
// Storage is deliberately not reset.
module iq_regfile #(
  parameter  int unsigned DEPTH  = 8,
  parameter  int unsigned INST_W = 64,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [AW-1:0]     i_waddr,
  input  logic [INST_W-1:0] i_wdata0,
  input  logic [INST_W-1:0] i_wdata1,
  input  logic [AW-1:0]     i_raddr,
  output logic [INST_W-1:0] o_rdata0,
  output logic [INST_W-1:0] o_rdata1
);

  logic [INST_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     w_waddr1;
  logic [AW-1:0]     w_raddr1;

  // DEPTH is a power of two, so natural wrap gives mod DEPTH.
  assign w_waddr1 = i_waddr + 1'b1;
  assign w_raddr1 = i_raddr + 1'b1;

  always_ff @(posedge clk) begin
    if (i_we0) r_mem[i_waddr]  <= i_wdata0;
    if (i_we1) r_mem[w_waddr1] <= i_wdata1;
  end

  assign o_rdata0 = r_mem[i_raddr];
  assign o_rdata1 = r_mem[w_raddr1];

endmodule

// File: rtl/id_issue_queue.sv
// Dual-issue instruction buffer between IF and the IF/ID register.
//   clk, rst_n                 : clock, async active-low reset
//   in_line{1,2}_valid_i/data_i: up to two fetched instructions (line1 older)
//   queue_allowin_o            : queue can take two instructions this cycle
//   out_allowin_i              : ID register accepts this cycle
//   out_line{1,2}_valid_o/data_o: oldest two entries, data 0 when invalid
//   excep_flush_i, branch_flush_i: discard all contents
//   count_o                    : current occupancy
module id_issue_queue
  import id_issue_queue_pkg::*;
#(
  parameter  int unsigned DEPTH  = 8,
  parameter  int unsigned INST_W = FETCH_BUS_W,
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_line1_valid_i,
  input  logic              in_line2_valid_i,
  input  logic [INST_W-1:0] in_line1_data_i,
  input  logic [INST_W-1:0] in_line2_data_i,
  output logic              queue_allowin_o,
  input  logic              out_allowin_i,
  output logic              out_line1_valid_o,
  output logic              out_line2_valid_o,
  output logic [INST_W-1:0] out_line1_data_o,
  output logic [INST_W-1:0] out_line2_data_o,
  input  logic              excep_flush_i,
  input  logic              branch_flush_i,
  output logic [CNT_W-1:0]  count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("id_issue_queue: DEPTH must be a power of two and at least 4");
  end

  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_flush;
  logic              w_allowin;
  logic [1:0]        w_push_n;
  logic [1:0]        w_pop_n;
  logic              w_we0;
  logic              w_we1;
  logic [INST_W-1:0] w_wdata0;
  logic              w_out1_valid;
  logic              w_out2_valid;
  logic [INST_W-1:0] w_rdata0;
  logic [INST_W-1:0] w_rdata1;

  assign w_flush   = excep_flush_i | branch_flush_i;
  // Two free slots required, so a full pair always fits; never looks at out_allowin_i.
  assign w_allowin = (r_count <= CNT_W'(DEPTH - 2)) && !w_flush;

  assign w_push_n = w_allowin ? pair_count(in_line1_valid_i, in_line2_valid_i) : 2'd0;

  // A lone line2 is compacted into the line1 write slot.
  assign w_we0    = w_allowin && (in_line1_valid_i || in_line2_valid_i);
  assign w_we1    = w_allowin && in_line1_valid_i && in_line2_valid_i;
  assign w_wdata0 = in_line1_valid_i ? in_line1_data_i : in_line2_data_i;

  assign w_out1_valid = (r_count >= CNT_W'(1)) && !w_flush;
  assign w_out2_valid = (r_count >= CNT_W'(2)) && !w_flush;

  assign w_pop_n = out_allowin_i ? pair_count(w_out1_valid, w_out2_valid) : 2'd0;

  iq_regfile #(
    .DEPTH  (DEPTH),
    .INST_W (INST_W)
  ) u_regfile (
    .clk      (clk),
    .i_we0    (w_we0),
    .i_we1    (w_we1),
    .i_waddr  (r_wr_ptr),
    .i_wdata0 (w_wdata0),
    .i_wdata1 (in_line2_data_i),
    .i_raddr  (r_rd_ptr),
    .o_rdata0 (w_rdata0),
    .o_rdata1 (w_rdata1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_N_ACTIVE) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_n);
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
      r_count  <= r_count + CNT_W'(w_push_n) - CNT_W'(w_pop_n);
    end
  end

  assign queue_allowin_o   = w_allowin;
  assign out_line1_valid_o = w_out1_valid;
  assign out_line2_valid_o = w_out2_valid;
  assign out_line1_data_o  = w_out1_valid ? w_rdata0 : '0;
  assign out_line2_data_o  = w_out2_valid ? w_rdata1 : '0;
  assign count_o           = r_count;

endmodule

// File: tb/tb_id_issue_queue.sv
module tb_id_issue_queue;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned INST_W = 64;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              v1 = 1'b0, v2 = 1'b0;
  logic [INST_W-1:0] d1 = '0, d2 = '0;
  logic              allowin;
  logic              oa = 1'b0;
  logic              ov1, ov2;
  logic [INST_W-1:0] od1, od2;
  logic              ef = 1'b0, bf = 1'b0;
  logic [CNT_W-1:0]  cnt;

  id_issue_queue #(
    .DEPTH  (DEPTH),
    .INST_W (INST_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_line1_valid_i  (v1),
    .in_line2_valid_i  (v2),
    .in_line1_data_i   (d1),
    .in_line2_data_i   (d2),
    .queue_allowin_o   (allowin),
    .out_allowin_i     (oa),
    .out_line1_valid_o (ov1),
    .out_line2_valid_o (ov2),
    .out_line1_data_o  (od1),
    .out_line2_data_o  (od2),
    .excep_flush_i     (ef),
    .branch_flush_i    (bf),
    .count_o           (cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic [INST_W-1:0] exp_q[$];
  int unsigned seq = 0;

  localparam logic [INST_W-1:0] A = 64'h1C000000_02800000;
  localparam logic [INST_W-1:0] B = 64'h1C000004_02800401;
  localparam logic [INST_W-1:0] C = 64'h1C000008_0280080C;

  function automatic logic [INST_W-1:0] pay(input int unsigned n);
    return {32'h1C001000 + 32'(n * 4), 32'h0A000000 + 32'(n)};
  endfunction

  task automatic chk(input string tag, input logic [INST_W-1:0] obs, input logic [INST_W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
  endtask

  task automatic idle();
    v1 = 1'b0; v2 = 1'b0; d1 = '0; d2 = '0; oa = 1'b0; ef = 1'b0; bf = 1'b0;
  endtask

  // Advance one clock edge, updating the reference queue from the driven inputs.
  task automatic cyc();
    int unsigned sz;
    bit acc;
    int unsigned pops;
    sz   = exp_q.size();
    acc  = (sz <= DEPTH - 2) && !(ef || bf);
    if (ef || bf) begin
      exp_q.delete();
    end else begin
      pops = oa ? ((sz >= 2) ? 2 : sz) : 0;
      for (int unsigned i = 0; i < pops; i++) void'(exp_q.pop_front());
      if (acc && v1) exp_q.push_back(d1);
      if (acc && v2) exp_q.push_back(d2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    int unsigned sz;
    logic [INST_W-1:0] e1, e2;
    sz = exp_q.size();
    e1 = (sz >= 1) ? exp_q[0] : '0;
    e2 = (sz >= 2) ? exp_q[1] : '0;
    chk({tag, ".count"}, INST_W'(cnt), INST_W'(sz));
    chk({tag, ".v1"},    INST_W'(ov1), INST_W'(sz >= 1));
    chk({tag, ".v2"},    INST_W'(ov2), INST_W'(sz >= 2));
    chk({tag, ".d1"},    od1, e1);
    chk({tag, ".d2"},    od2, e2);
  endtask

  task automatic push2();
    v1 = 1'b1; v2 = 1'b1; d1 = pay(seq); d2 = pay(seq + 1); seq += 2;
  endtask

  task automatic push1();
    v1 = 1'b1; d1 = pay(seq); seq += 1;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
      idle(); oa = 1'b1; cyc();
    end
    idle(); #1;
    chk("drain.count", INST_W'(cnt), '0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst.count",   INST_W'(cnt), '0);
    chk("rst.allowin", INST_W'(allowin), 1);
    chk("rst.v1",      INST_W'(ov1), 0);
    chk("rst.v2",      INST_W'(ov2), 0);
    chk("rst.d1",      od1, '0);
    chk("rst.d2",      od2, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single pushes, no bypass
    v1 = 1'b1; d1 = A; #1;
    chk("t1.nobypass", INST_W'(ov1), 0);
    cyc(); idle(); #1;
    chk("t1.count1", INST_W'(cnt), 1);
    chk("t1.v1",     INST_W'(ov1), 1);
    chk("t1.d1",     od1, A);
    chk("t1.v2",     INST_W'(ov2), 0);
    v1 = 1'b1; d1 = B;
    cyc(); idle(); #1;
    chk("t1.count2", INST_W'(cnt), 2);
    chk("t1.d1b",    od1, A);
    chk("t1.v2b",    INST_W'(ov2), 1);
    chk("t1.d2b",    od2, B);
    oa = 1'b1; cyc(); idle(); #1;
    chk("t1.popped", INST_W'(cnt), 0);

    // 2: compaction of a lone line2
    v2 = 1'b1; d2 = C;
    cyc(); idle(); #1;
    chk("t2.d1",    od1, C);
    chk("t2.v2",    INST_W'(ov2), 0);
    chk("t2.count", INST_W'(cnt), 1);
    oa = 1'b1; cyc(); idle(); #1;

    // 3: fill, allowin boundaries, wrap with steady push/pop
    for (int i = 0; i < 3; i++) begin
      push2(); cyc(); idle();
    end
    #1;
    chk("t3.count6",   INST_W'(cnt), 6);
    chk("t3.allow6",   INST_W'(allowin), 1);
    push1(); cyc(); idle(); #1;
    chk("t3.count7",   INST_W'(cnt), 7);
    chk("t3.allow7",   INST_W'(allowin), 0);
    push2(); cyc(); idle(); #1;
    check_model("t3.reject7");
    oa = 1'b1; cyc(); idle(); #1;
    chk("t3.count5",   INST_W'(cnt), 5);
    push1(); cyc(); idle();
    push2(); cyc(); idle(); #1;
    chk("t3.count8",   INST_W'(cnt), 8);
    chk("t3.allow8",   INST_W'(allowin), 0);
    check_model("t3.full");
    push2(); cyc(); idle(); #1;
    chk("t3.stay8",    INST_W'(cnt), 8);
    for (int i = 0; i < 10; i++) begin
      push2(); oa = 1'b1; cyc(); idle(); #1;
      check_model("t3.stream");
    end
    drain();

    // 4: simultaneous push/pop at count 3
    push2(); cyc(); idle();
    push1(); cyc(); idle(); #1;
    chk("t4.count3", INST_W'(cnt), 3);
    begin
      logic [INST_W-1:0] third, fourth;
      third  = exp_q[2];
      fourth = pay(seq);
      push2(); oa = 1'b1; cyc(); idle(); #1;
      chk("t4.count", INST_W'(cnt), 3);
      chk("t4.head",  od1, third);
      chk("t4.next",  od2, fourth);
    end
    drain();

    // 5: branch flush priority over push and pop
    push2(); cyc(); idle();
    push2(); cyc(); idle();
    push1(); cyc(); idle(); #1;
    chk("t5.count5", INST_W'(cnt), 5);
    bf = 1'b1; oa = 1'b1; push2(); #1;
    chk("t5.v1",      INST_W'(ov1), 0);
    chk("t5.v2",      INST_W'(ov2), 0);
    chk("t5.allowin", INST_W'(allowin), 0);
    chk("t5.d1",      od1, '0);
    cyc(); idle(); #1;
    check_model("t5.after");
    chk("t5.count0",  INST_W'(cnt), 0);
    push1(); cyc(); idle(); #1;
    check_model("t5.fresh");
    ef = 1'b1; cyc(); idle(); #1;
    chk("t5.excep",   INST_W'(cnt), 0);
    push1(); cyc(); idle(); #1;

    // 6: async reset mid-cycle
    push2(); cyc(); idle();
    push1(); cyc(); idle(); #1;
    chk("t6.count4", INST_W'(cnt), 4);
    #3 rst_n = 1'b0;
    #1;
    chk("t6.count",   INST_W'(cnt), 0);
    chk("t6.v1",      INST_W'(ov1), 0);
    chk("t6.v2",      INST_W'(ov2), 0);
    chk("t6.allowin", INST_W'(allowin), 1);
    exp_q.delete();
    #2 rst_n = 1'b1;
    v1 = 1'b1; d1 = A; cyc(); idle(); #1;
    chk("t6.head",    od1, A);
    chk("t6.count1",  INST_W'(cnt), 1);
    check_model("t6.model");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
